fft16_frame_sched: RTL and testbench

- Frame scheduler for the 16-point FFT datapath and its output reorder/scale stage.
- Collects 16 complex samples from a serial valid/ready stream into a parallel input bank and drives the bank onto the FFT input buses.
- Launches the datapath, waits a fixed latency, then captures the parallel result buses into an output bank.
- Streams the results out serially. Input and output banks are independent, so filling frame k+1 overlaps draining frame k.

---
 rtl/fft16_pkg.sv | 25 ++
 rtl/fft16_slot_bank.sv | 40 ++++
 rtl/fft16_frame_sched.sv | 168 ++++++++++++++++
 tb/tb_fft16_frame_sched.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft16_pkg.sv
// Shared constants, FSM state types and slot-packing helper for the 16-point
// FFT frame scheduler.
package fft16_pkg;

    localparam int unsigned FFT_PTS = 16;
    localparam int unsigned IDX_W   = 4;
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(FFT_PTS - 1);

    typedef enum logic {
        FILL,
        FULL
    } in_state_e;

    typedef enum logic [1:0] {
        EMPTY,
        COMPUTE,
        DRAIN
    } out_state_e;

    // Bit offset of slot idx inside a flattened bus of w-bit slots.
    function automatic logic [31:0] slot_lsb(input logic [IDX_W-1:0] idx, input int unsigned w);
        return 32'(idx) * w;
    endfunction

endpackage

// File: rtl/fft16_slot_bank.sv
// 16-slot complex register bank: single-slot write, whole-bank parallel load,
// flattened read buses. Parallel load takes priority over the slot write.
module fft16_slot_bank
    import fft16_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en_i,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  logic [N-1:0]         wr_re_i,
    input  logic [N-1:0]         wr_im_i,
    input  logic                 ld_en_i,
    input  logic [FFT_PTS*N-1:0] ld_re_bus_i,
    input  logic [FFT_PTS*N-1:0] ld_im_bus_i,
    output logic [FFT_PTS*N-1:0] re_bus_o,
    output logic [FFT_PTS*N-1:0] im_bus_o
);

    logic [FFT_PTS*N-1:0] re_q;
    logic [FFT_PTS*N-1:0] im_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            re_q <= '0;
            im_q <= '0;
        end else if (ld_en_i) begin
            re_q <= ld_re_bus_i;
            im_q <= ld_im_bus_i;
        end else if (wr_en_i) begin
            re_q[slot_lsb(wr_idx_i, N) +: N] <= wr_re_i;
            im_q[slot_lsb(wr_idx_i, N) +: N] <= wr_im_i;
        end
    end

    assign re_bus_o = re_q;
    assign im_bus_o = im_q;

endmodule

// File: rtl/fft16_frame_sched.sv
// Frame scheduler: serial input -> 16-slot input bank -> FFT launch/wait ->
// output bank capture -> serial drain. Input and output sides run independently.
module fft16_frame_sched
    import fft16_pkg::*;
#(
    parameter int unsigned N       = 16,
    parameter int unsigned FFT_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [N-1:0]         s_re,
    input  logic [N-1:0]         s_im,
    input  logic                 s_last,
    output logic [FFT_PTS*N-1:0] fft_re_bus,
    output logic [FFT_PTS*N-1:0] fft_im_bus,
    output logic                 fft_start,
    input  logic [FFT_PTS*N-1:0] res_re_bus,
    input  logic [FFT_PTS*N-1:0] res_im_bus,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [N-1:0]         m_re,
    output logic [N-1:0]         m_im,
    output logic [IDX_W-1:0]     m_index,
    output logic                 m_last,
    output logic                 busy,
    output logic                 frame_err,
    output logic [15:0]          frame_cnt
);

    in_state_e            in_state_q, in_state_d;
    logic [IDX_W-1:0]     in_cnt_q, in_cnt_d;
    out_state_e           out_state_q, out_state_d;
    logic [IDX_W-1:0]     out_idx_q, out_idx_d;
    logic [3:0]           lat_q, lat_d;
    logic                 fft_start_q, fft_start_d;
    logic                 frame_err_q, frame_err_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 rdy_q;
    logic                 s_hs;
    logic                 capture;
    logic [FFT_PTS*N-1:0] out_re_bus, out_im_bus;

    // rdy_q keeps s_ready low while reset is asserted and for no longer.
    assign s_ready = rdy_q && (in_state_q == FILL);
    assign s_hs    = s_valid && s_ready;
    assign capture = (out_state_q == COMPUTE) && (lat_q == 4'd1);

    always_comb begin
        in_state_d  = in_state_q;
        in_cnt_d    = in_cnt_q;
        frame_err_d = 1'b0;
        if (s_hs) begin
            if ((in_cnt_q == LAST_SLOT) && s_last) begin
                in_state_d = FULL;
                in_cnt_d   = '0;
            end else if ((in_cnt_q == LAST_SLOT) || s_last) begin
                frame_err_d = 1'b1;
                in_cnt_d    = '0;
            end else begin
                in_cnt_d = in_cnt_q + 4'd1;
            end
        end
        if (capture) begin
            in_state_d = FILL;
        end

        out_state_d = out_state_q;
        out_idx_d   = out_idx_q;
        lat_d       = lat_q;
        frame_cnt_d = frame_cnt_q;
        case (out_state_q)
            EMPTY: begin
                if (fft_start_q) begin
                    out_state_d = COMPUTE;
                    lat_d       = 4'(FFT_LAT);
                end
            end
            COMPUTE: begin
                if (lat_q == 4'd1) begin
                    out_state_d = DRAIN;
                    out_idx_d   = '0;
                    lat_d       = '0;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            DRAIN: begin
                if (m_ready) begin
                    out_idx_d = out_idx_q + 4'd1;
                    if (out_idx_q == LAST_SLOT) begin
                        out_state_d = EMPTY;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end
            end
            default: out_state_d = EMPTY;
        endcase

        // Decided from next-state so the pulse lands in the first eligible cycle,
        // including the cycle right after the final output handshake.
        fft_start_d = (in_state_d == FULL) && (out_state_d == EMPTY) && (lat_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state_q  <= FILL;
            in_cnt_q    <= '0;
            out_state_q <= EMPTY;
            out_idx_q   <= '0;
            lat_q       <= '0;
            fft_start_q <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
            rdy_q       <= 1'b0;
        end else begin
            in_state_q  <= in_state_d;
            in_cnt_q    <= in_cnt_d;
            out_state_q <= out_state_d;
            out_idx_q   <= out_idx_d;
            lat_q       <= lat_d;
            fft_start_q <= fft_start_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
            rdy_q       <= 1'b1;
        end
    end

    fft16_slot_bank #(.N(N)) u_in_bank (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (s_hs),
        .wr_idx_i    (in_cnt_q),
        .wr_re_i     (s_re),
        .wr_im_i     (s_im),
        .ld_en_i     (1'b0),
        .ld_re_bus_i ('0),
        .ld_im_bus_i ('0),
        .re_bus_o    (fft_re_bus),
        .im_bus_o    (fft_im_bus)
    );

    fft16_slot_bank #(.N(N)) u_out_bank (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (1'b0),
        .wr_idx_i    ('0),
        .wr_re_i     ('0),
        .wr_im_i     ('0),
        .ld_en_i     (capture),
        .ld_re_bus_i (res_re_bus),
        .ld_im_bus_i (res_im_bus),
        .re_bus_o    (out_re_bus),
        .im_bus_o    (out_im_bus)
    );

    assign fft_start = fft_start_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = (in_state_q == FULL) || (out_state_q != EMPTY);
    assign m_valid   = (out_state_q == DRAIN);
    assign m_index   = out_idx_q;
    assign m_last    = (out_idx_q == LAST_SLOT);
    assign m_re      = out_re_bus[slot_lsb(out_idx_q, N) +: N];
    assign m_im      = out_im_bus[slot_lsb(out_idx_q, N) +: N];

endmodule

// File: tb/tb_fft16_frame_sched.sv
// Bench for fft16_frame_sched: two loopback instances (FFT_LAT=2 and 1) checked
// against a frame-level pass-through model.
module tb_fft16_frame_sched;

    localparam int N = 16;

    typedef struct packed {
        logic [N-1:0] re;
        logic [N-1:0] im;
        logic [3:0]   idx;
        logic         last;
    } samp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]              s_valid = '0, s_ready, s_last = '0;
    logic [1:0][N-1:0]       s_re = '0, s_im = '0, m_re, m_im;
    logic [1:0][16*N-1:0]    fft_re, fft_im;
    logic [1:0]              fft_start, m_valid, m_last, busy, frame_err;
    logic [1:0]              m_ready = '0;
    logic [1:0][3:0]         m_index;
    logic [1:0][15:0]        frame_cnt;

    fft16_frame_sched #(.N(N), .FFT_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .s_re(s_re[0]), .s_im(s_im[0]), .s_last(s_last[0]),
        .fft_re_bus(fft_re[0]), .fft_im_bus(fft_im[0]), .fft_start(fft_start[0]),
        .res_re_bus(fft_re[0]), .res_im_bus(fft_im[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_re(m_re[0]), .m_im(m_im[0]),
        .m_index(m_index[0]), .m_last(m_last[0]), .busy(busy[0]),
        .frame_err(frame_err[0]), .frame_cnt(frame_cnt[0])
    );

    fft16_frame_sched #(.N(N), .FFT_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .s_re(s_re[1]), .s_im(s_im[1]), .s_last(s_last[1]),
        .fft_re_bus(fft_re[1]), .fft_im_bus(fft_im[1]), .fft_start(fft_start[1]),
        .res_re_bus(fft_re[1]), .res_im_bus(fft_im[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_re(m_re[1]), .m_im(m_im[1]),
        .m_index(m_index[1]), .m_last(m_last[1]), .busy(busy[1]),
        .frame_err(frame_err[1]), .frame_cnt(frame_cnt[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_run = 0;
    int n_fail = 0;

    samp_t rx [2][256];
    samp_t ex [2][256];
    int rx_n [2] = '{0, 0};
    int ex_n [2] = '{0, 0};
    int chk_n [2] = '{0, 0};
    int last_hs [2];
    int start_cnt [2] = '{0, 0};
    int err_cnt [2] = '{0, 0};
    int start_cyc [2], err_cyc [2], mv_rise_cyc [2], last_out_edge [2], last_edge_at_start [2];
    logic mv_prev [2] = '{1'b0, 1'b0};

    // Passive monitor; a handshake seen here completes on the following posedge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (m_valid[d] && m_ready[d] && rx_n[d] < 256) begin
                rx[d][rx_n[d]] = '{m_re[d], m_im[d], m_index[d], m_last[d]};
                rx_n[d]++;
                if (m_last[d]) last_out_edge[d] = cyc + 1;
            end
            if (fft_start[d]) begin
                start_cnt[d]++;
                start_cyc[d] = cyc;
                last_edge_at_start[d] = last_out_edge[d];
            end
            if (frame_err[d]) begin
                err_cnt[d]++;
                err_cyc[d] = cyc;
            end
            if (m_valid[d] && !mv_prev[d]) mv_rise_cyc[d] = cyc;
            mv_prev[d] = m_valid[d];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int d, input logic [N-1:0] re, input logic [N-1:0] im, input logic last);
        int unsigned t = 0;
        s_re[d] = re; s_im[d] = im; s_last[d] = last; s_valid[d] = 1'b1;
        @(negedge clk);
        while (!s_ready[d] && t < 400) begin @(negedge clk); t++; end
        chk("s_ready_wait", 64'(s_ready[d]), 64'd1);
        @(posedge clk); #1;
        last_hs[d] = cyc;
        s_valid[d] = 1'b0; s_last[d] = 1'b0;
    endtask

    // Model: a frame passes through unchanged only if s_last marks exactly its 16th sample.
    task automatic push_frame(input int d, input int n, input int last_at, input bit ramp);
        samp_t f [16];
        for (int k = 0; k < n; k++) begin
            logic [N-1:0] re, im;
            re = ramp ? N'(k) : N'($urandom);
            im = ramp ? -N'(k) : N'($urandom);
            f[k] = '{re, im, 4'(k), (k == 15)};
            push(d, re, im, k == last_at);
        end
        if (n == 16 && last_at == 15)
            for (int k = 0; k < 16; k++) begin
                ex[d][ex_n[d]] = f[k];
                ex_n[d]++;
            end
    endtask

    task automatic check_rx(input int d, input string tag);
        int unsigned t = 0;
        while (rx_n[d] < ex_n[d] && t < 3000) begin @(negedge clk); t++; end
        chk({tag, "_count"}, 64'(rx_n[d]), 64'(ex_n[d]));
        for (int i = chk_n[d]; i < ex_n[d]; i++)
            chk($sformatf("%s_out%0d", tag, i), 64'(rx[d][i]), 64'(ex[d][i]));
        chk_n[d] = ex_n[d];
        @(posedge clk); #1;
    endtask

    task automatic wait_mvalid(input int d);
        int unsigned t = 0;
        while (!m_valid[d] && t < 200) begin @(negedge clk); t++; end
        chk("m_valid_wait", 64'(m_valid[d]), 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;

        // Reset state
        #22;
        chk("rst_s_ready", 64'(s_ready[0]), 64'd0);
        chk("rst_m_valid", 64'(m_valid[0]), 64'd0);
        chk("rst_busy", 64'(busy[0]), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt[0]), 64'd0);
        chk("rst_fft_start", 64'(fft_start[0]), 64'd0);
        chk("rst_frame_err", 64'(frame_err[0]), 64'd0);
        chk("rst_fft_bus", 64'(fft_re[0] | fft_im[0]), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_s_ready", 64'(s_ready[0]), 64'd1);

        // Loopback ramp frame
        m_ready[0] = 1'b1;
        push_frame(0, 16, 15, 1'b1);
        e = last_hs[0];
        check_rx(0, "ramp");
        chk("ramp_start_cyc", 64'(start_cyc[0]), 64'(e));
        chk("ramp_first_mvalid", 64'(mv_rise_cyc[0]), 64'(e + 3));
        chk("ramp_start_cnt", 64'(start_cnt[0]), 64'd1);
        chk("ramp_frame_cnt", 64'(frame_cnt[0]), 64'd1);

        // Early s_last at sample 7
        push_frame(0, 8, 7, 1'b0);
        e = last_hs[0];
        repeat (4) @(posedge clk); #1;
        chk("early_err_cnt", 64'(err_cnt[0]), 64'd1);
        chk("early_err_cyc", 64'(err_cyc[0]), 64'(e));
        chk("early_no_start", 64'(start_cnt[0]), 64'd1);
        chk("early_frame_cnt", 64'(frame_cnt[0]), 64'd1);
        chk("early_busy", 64'(busy[0]), 64'd0);
        push_frame(0, 16, 15, 1'b0);
        check_rx(0, "clean");
        chk("clean_frame_cnt", 64'(frame_cnt[0]), 64'd2);

        // 16 samples with no s_last
        push_frame(0, 16, -1, 1'b0);
        e = last_hs[0];
        repeat (4) @(posedge clk); #1;
        chk("nolast_err_cnt", 64'(err_cnt[0]), 64'd2);
        chk("nolast_err_cyc", 64'(err_cyc[0]), 64'(e));
        chk("nolast_no_start", 64'(start_cnt[0]), 64'd2);
        chk("nolast_busy", 64'(busy[0]), 64'd0);

        // Output backpressure with a second frame queued behind it
        m_ready[0] = 1'b0;
        push_frame(0, 16, 15, 1'b0);
        wait_mvalid(0);
        @(posedge clk); #1 m_ready[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 m_ready[0] = 1'b0;
        push_frame(0, 16, 15, 1'b0);
        repeat (6) @(posedge clk); #1;
        chk("bp_s_ready", 64'(s_ready[0]), 64'd0);
        chk("bp_start_held", 64'(start_cnt[0]), 64'd3);
        chk("bp_m_valid", 64'(m_valid[0]), 64'd1);
        chk("bp_m_index", 64'(m_index[0]), 64'd3);
        chk("bp_m_re_hold", 64'(m_re[0]), 64'(ex[0][chk_n[0] + 3].re));
        m_ready[0] = 1'b1;
        check_rx(0, "bp");
        chk("bp_start_after_drain", 64'(last_edge_at_start[0]), 64'(start_cyc[0]));
        chk("bp_start_cnt", 64'(start_cnt[0]), 64'd4);
        chk("bp_frame_cnt", 64'(frame_cnt[0]), 64'd4);

        // Asynchronous reset mid-drain
        m_ready[0] = 1'b0;
        push_frame(0, 16, 15, 1'b0);
        wait_mvalid(0);
        @(posedge clk); #1 m_ready[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1 m_ready[0] = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst_m_valid", 64'(m_valid[0]), 64'd0);
        chk("arst_busy", 64'(busy[0]), 64'd0);
        chk("arst_frame_cnt", 64'(frame_cnt[0]), 64'd0);
        ex_n[0] = chk_n[0] + 5;
        check_rx(0, "arst_partial");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_rel_s_ready", 64'(s_ready[0]), 64'd1);
        m_ready[0] = 1'b1;
        push_frame(0, 16, 15, 1'b0);
        check_rx(0, "after_rst");
        chk("after_rst_frame_cnt", 64'(frame_cnt[0]), 64'd1);

        // Continuous traffic on the FFT_LAT=1 instance
        m_ready[1] = 1'b1;
        for (int f = 0; f < 4; f++) push_frame(1, 16, 15, 1'b0);
        check_rx(1, "cont");
        repeat (2) @(posedge clk); #1;
        chk("cont_frame_cnt", 64'(frame_cnt[1]), 64'd4);
        chk("cont_err_cnt", 64'(err_cnt[1]), 64'd0);
        chk("cont_start_cnt", 64'(start_cnt[1]), 64'd4);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
